// File: rtl/hdmi_pkg.sv
// Shared HDMI/TMDS definitions: control-token codes, alignment FSM states, counter sizing.
package hdmi_pkg;

   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LOCKED = 2'd3
   } align_state_e;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational recognition of the four TMDS control tokens.
module tmds_token_detect
   import hdmi_pkg::*;
(
   input  logic [9:0] datain,
   output logic       is_ctrl,
   output logic [1:0] ctrl
);

   // Match the current word against the control-token codes.
   always_comb begin
      is_ctrl = 1'b1;
      ctrl    = 2'b00;
      case (datain)
         TMDS_CTRL_00: ctrl = 2'b00;
         TMDS_CTRL_01: ctrl = 2'b01;
         TMDS_CTRL_10: ctrl = 2'b10;
         TMDS_CTRL_11: ctrl = 2'b11;
         default: begin
            is_ctrl = 1'b0;
            ctrl    = 2'b00;
         end
      endcase
   end

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS word-boundary alignment: hunts for runs of control tokens, bit-slips the
// deserializer when a search window expires, and watches for loss of lock.
module tmds_align_ctrl
   import hdmi_pkg::*;
#(
   parameter int unsigned SEARCH_WIN = 4096,
   parameter int unsigned TOKEN_RUN  = 8,
   parameter int unsigned SLIP_WAIT  = 16,
   parameter int unsigned LOSS_WIN   = 65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [9:0] datain,
   output logic       bitslip,
   output logic       locked,
   output logic [3:0] slip_cnt,
   output logic       align_err
);

   localparam int unsigned WIN_W    = cnt_width(SEARCH_WIN);
   localparam int unsigned RUN_W    = cnt_width(TOKEN_RUN);
   localparam int unsigned SETTLE_W = cnt_width(SLIP_WAIT);
   localparam int unsigned LOSS_W   = cnt_width(LOSS_WIN);

   localparam logic [WIN_W-1:0]    WIN_MAX    = WIN_W'(SEARCH_WIN - 1);
   localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(TOKEN_RUN - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SLIP_WAIT - 1);
   localparam logic [LOSS_W-1:0]   LOSS_MAX   = LOSS_W'(LOSS_WIN - 1);
   localparam logic [3:0]          POS_LAST   = 4'd9;

   logic       is_ctrl;
   logic [1:0] ctrl_unused;

   align_state_e        state_q,     state_d;
   logic [WIN_W-1:0]    win_cnt_q,   win_cnt_d;
   logic [RUN_W-1:0]    run_cnt_q,   run_cnt_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [LOSS_W-1:0]   loss_cnt_q,  loss_cnt_d;
   logic [3:0]          slip_cnt_q,  slip_cnt_d;
   logic                bitslip_q,   bitslip_d;
   logic                locked_q,    locked_d;
   logic                align_err_q, align_err_d;

   tmds_token_detect u_detect (
      .datain  (datain),
      .is_ctrl (is_ctrl),
      .ctrl    (ctrl_unused)
   );

   // Next-state, counter and output decode; outputs are registered from the _d values.
   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      run_cnt_d    = run_cnt_q;
      settle_cnt_d = settle_cnt_q;
      loss_cnt_d   = loss_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      bitslip_d    = 1'b0;
      locked_d     = 1'b0;
      align_err_d  = 1'b0;

      if (!en) begin
         state_d      = ST_SEARCH;
         win_cnt_d    = '0;
         run_cnt_d    = '0;
         settle_cnt_d = '0;
         loss_cnt_d   = '0;
      end else begin
         case (state_q)
            ST_SEARCH: begin
               if (is_ctrl && (run_cnt_q == RUN_MAX)) begin
                  // A completed token run takes priority over an expiring window.
                  state_d    = ST_LOCKED;
                  locked_d   = 1'b1;
                  win_cnt_d  = '0;
                  run_cnt_d  = '0;
                  loss_cnt_d = '0;
               end else if (win_cnt_q == WIN_MAX) begin
                  state_d     = ST_SLIP;
                  bitslip_d   = 1'b1;
                  win_cnt_d   = '0;
                  run_cnt_d   = '0;
                  slip_cnt_d  = (slip_cnt_q == POS_LAST) ? 4'd0 : slip_cnt_q + 4'd1;
                  align_err_d = (slip_cnt_q == POS_LAST);
               end else begin
                  win_cnt_d = win_cnt_q + WIN_W'(1);
                  run_cnt_d = is_ctrl ? run_cnt_q + RUN_W'(1) : '0;
               end
            end

            ST_SLIP: begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
            end

            ST_SETTLE: begin
               // Deserializer output is untrusted while it re-frames; datain ignored.
               if (settle_cnt_q == SETTLE_MAX) begin
                  state_d      = ST_SEARCH;
                  settle_cnt_d = '0;
                  win_cnt_d    = '0;
                  run_cnt_d    = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
               end
            end

            ST_LOCKED: begin
               locked_d = 1'b1;
               if (is_ctrl) begin
                  loss_cnt_d = '0;
               end else if (loss_cnt_q == LOSS_MAX) begin
                  state_d    = ST_SEARCH;
                  locked_d   = 1'b0;
                  loss_cnt_d = '0;
                  win_cnt_d  = '0;
                  run_cnt_d  = '0;
               end else begin
                  loss_cnt_d = loss_cnt_q + LOSS_W'(1);
               end
            end

            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end
   end

   // State, counter and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_SEARCH;
         win_cnt_q    <= '0;
         run_cnt_q    <= '0;
         settle_cnt_q <= '0;
         loss_cnt_q   <= '0;
         slip_cnt_q   <= '0;
         bitslip_q    <= 1'b0;
         locked_q     <= 1'b0;
         align_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_cnt_q    <= win_cnt_d;
         run_cnt_q    <= run_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         bitslip_q    <= bitslip_d;
         locked_q     <= locked_d;
         align_err_q  <= align_err_d;
      end
   end

   assign bitslip   = bitslip_q;
   assign locked    = locked_q;
   assign slip_cnt  = slip_cnt_q;
   assign align_err = align_err_q;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Randomized self-checking bench for tmds_align_ctrl against a timeline model.
module tb_tmds_align_ctrl;

   localparam int SW = 32;
   localparam int TR = 8;
   localparam int WT = 4;
   localparam int LW = 64;

   logic       clk;
   logic       rst;
   logic       en;
   logic [9:0] datain;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_cnt;
   logic       align_err;

   int checks;
   int errors;

   // Reference model: elapsed-time view of the alignment process.
   logic m_bitslip;
   logic m_err;
   logic m_locked;
   int   m_pos;
   int   m_ignore;
   int   m_search_len;
   int   m_streak;
   int   m_quiet;

   tmds_align_ctrl #(
      .SEARCH_WIN (SW),
      .TOKEN_RUN  (TR),
      .SLIP_WAIT  (WT),
      .LOSS_WIN   (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .datain    (datain),
      .bitslip   (bitslip),
      .locked    (locked),
      .slip_cnt  (slip_cnt),
      .align_err (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_tok(input logic [9:0] w);
      return (w == 10'b1101010100) || (w == 10'b0010101011) ||
             (w == 10'b0101010100) || (w == 10'b1010101011);
   endfunction

   function automatic logic [9:0] rand_tok();
      logic [9:0] t;
      case ($urandom_range(0, 3))
         0:       t = 10'b1101010100;
         1:       t = 10'b0010101011;
         2:       t = 10'b0101010100;
         default: t = 10'b1010101011;
      endcase
      return t;
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      w = 10'($urandom);
      while (is_tok(w)) w = 10'($urandom);
      return w;
   endfunction

   function automatic logic [6:0] obs();
      return {bitslip, locked, slip_cnt, align_err};
   endfunction

   function automatic logic [6:0] exp_vec();
      return {m_bitslip, m_locked, 4'(m_pos), m_err};
   endfunction

   task automatic model_reset();
      m_bitslip = 1'b0; m_err = 1'b0; m_locked = 1'b0; m_pos = 0;
      m_ignore = 0; m_search_len = 0; m_streak = 0; m_quiet = 0;
   endtask

   // One word accepted at a rising edge: advance the expected timeline.
   task automatic model_step(input logic [9:0] w, input logic e);
      m_bitslip = 1'b0;
      m_err     = 1'b0;
      if (!e) begin
         m_locked = 1'b0; m_ignore = 0; m_search_len = 0; m_streak = 0; m_quiet = 0;
      end else if (m_ignore > 0) begin
         m_ignore--;
      end else if (m_locked) begin
         if (is_tok(w)) m_quiet = 0;
         else begin
            m_quiet++;
            if (m_quiet == LW) begin
               m_locked = 1'b0; m_search_len = 0; m_streak = 0;
            end
         end
      end else begin
         m_search_len++;
         m_streak = is_tok(w) ? m_streak + 1 : 0;
         if (m_streak == TR) begin
            m_locked = 1'b1; m_quiet = 0; m_search_len = 0; m_streak = 0;
         end else if (m_search_len == SW) begin
            m_bitslip = 1'b1;
            m_pos = (m_pos + 1) % 10;
            m_err = (m_pos == 0);
            m_ignore = 1 + WT;
            m_search_len = 0; m_streak = 0;
         end
      end
   endtask

   task automatic step(input logic [9:0] w, input logic e);
      datain = w;
      en     = e;
      @(posedge clk);
      #1;
      model_step(w, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; datain = 10'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; datain = 10'd0;
      #1;
      checks++;
      if (obs() !== 7'd0) begin
         errors++; $display("FAIL reset_async got %b want %b", obs(), 7'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 7'd0) begin
         errors++; $display("FAIL reset_held got %b want %b", obs(), 7'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_lock_basic();
      int slips;
      slips = 0;
      do_reset();
      for (int i = 1; i <= TR; i++) begin
         step(10'b1101010100, 1'b1);
         slips += int'(bitslip);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL lock_basic cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      checks++;
      if ({locked, slip_cnt, slips[0]} !== {1'b1, 4'd0, 1'b0}) begin
         errors++; $display("FAIL lock_basic_final locked %b slip_cnt %0d slips %0d want 1 0 0",
                            locked, slip_cnt, slips);
      end
   endtask

   task automatic test_slip_single();
      int slips;
      do_reset();
      for (int i = 1; i <= SW; i++) begin
         step(rand_data(), 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL slip_single cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      checks++;
      if ({bitslip, slip_cnt} !== {1'b1, 4'd1}) begin
         errors++; $display("FAIL slip_first bitslip %b slip_cnt %0d want 1 1", bitslip, slip_cnt);
      end
      slips = 0;
      for (int i = 1; i <= 1 + WT + SW - 1; i++) begin
         step(rand_data(), 1'b1);
         slips += int'(bitslip);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL slip_gap cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      checks++;
      if (slips != 0) begin
         errors++; $display("FAIL slip_spacing pulses %0d want 0", slips);
      end
      step(rand_data(), 1'b1);
      checks++;
      if ({bitslip, slip_cnt} !== {1'b1, 4'd2}) begin
         errors++; $display("FAIL slip_second bitslip %b slip_cnt %0d want 1 2", bitslip, slip_cnt);
      end
   endtask

   task automatic test_sweep();
      int slips;
      logic err_at_tenth;
      logic [3:0] pos_at_tenth;
      int errs_seen;
      slips = 0; errs_seen = 0; err_at_tenth = 1'b0; pos_at_tenth = 4'hf;
      do_reset();
      for (int i = 1; i <= SW + 9 * (1 + WT + SW) + 3; i++) begin
         step(rand_data(), 1'b1);
         if (bitslip) begin
            slips++;
            if (slips == 10) begin
               err_at_tenth = align_err;
               pos_at_tenth = slip_cnt;
            end
         end
         errs_seen += int'(align_err);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL sweep cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      checks++;
      if (slips != 10 || errs_seen != 1 || err_at_tenth !== 1'b1 || pos_at_tenth !== 4'd0) begin
         errors++;
         $display("FAIL sweep_summary slips %0d errs %0d err10 %b pos10 %0d want 10 1 1 0",
                  slips, errs_seen, err_at_tenth, pos_at_tenth);
      end
   endtask

   task automatic test_loss();
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < TR; i++) step(rand_tok(), 1'b1);
         for (int i = 1; i <= LW - 1 + (pass * 40); i++) begin
            step((pass == 1 && i == 40) ? rand_tok() : rand_data(), 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
               errors++; $display("FAIL loss p%0d word %0d got %b want %b", pass, i, obs(), exp_vec());
            end
         end
         checks++;
         if (locked !== 1'b1) begin
            errors++; $display("FAIL loss_hold p%0d locked %b want 1", pass, locked);
         end
         step(rand_data(), 1'b1);
         checks++;
         if (locked !== 1'b0) begin
            errors++; $display("FAIL loss_drop p%0d locked %b want 0", pass, locked);
         end
      end
   endtask

   task automatic test_run_break();
      do_reset();
      for (int i = 1; i <= 2 * TR; i++) begin
         step((i <= TR - 1) ? 10'b1101010100 : (i == TR) ? 10'h155 : 10'b0010101011, 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL run_break cyc %0d got %b want %b", i, obs(), exp_vec());
         end
         if (i == 2 * TR - 1) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++; $display("FAIL run_break_early locked %b want 0", locked);
            end
         end
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL run_break_lock locked %b want 1", locked);
      end
      do_reset();
      for (int i = 1; i <= SW; i++) begin
         step((i > SW - TR) ? rand_tok() : rand_data(), 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL edge_lock cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      checks++;
      if ({locked, bitslip, slip_cnt} !== {1'b1, 1'b0, 4'd0}) begin
         errors++; $display("FAIL edge_lock_final locked %b bitslip %b slip_cnt %0d want 1 0 0",
                            locked, bitslip, slip_cnt);
      end
   endtask

   task automatic test_abort();
      // Reset asserted between edges while settling.
      do_reset();
      for (int i = 0; i < SW + 2; i++) step(rand_data(), 1'b1);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== 7'd0) begin
         errors++; $display("FAIL rst_settle got %b want %b", obs(), 7'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 1; i <= SW; i++) begin
         step(rand_data(), 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL rst_resume cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
      // Enable dropped while locked; slip position must survive.
      for (int i = 0; i < 1 + WT; i++) step(rand_data(), 1'b1);
      for (int i = 0; i < TR; i++) step(rand_tok(), 1'b1);
      checks++;
      if ({locked, slip_cnt} !== {1'b1, 4'd1}) begin
         errors++; $display("FAIL en_pre locked %b slip_cnt %0d want 1 1", locked, slip_cnt);
      end
      step(rand_tok(), 1'b0);
      checks++;
      if ({bitslip, locked, slip_cnt, align_err} !== {1'b0, 1'b0, 4'd1, 1'b0}) begin
         errors++; $display("FAIL en_off got %b want %b", obs(), {1'b0, 1'b0, 4'd1, 1'b0});
      end
   endtask

   task automatic test_random();
      int tok_pct;
      do_reset();
      tok_pct = 50;
      for (int i = 1; i <= 3000; i++) begin
         if (i % 150 == 1) begin
            case ($urandom_range(0, 3))
               0:       tok_pct = 0;
               1:       tok_pct = 3;
               2:       tok_pct = 60;
               default: tok_pct = 95;
            endcase
         end
         step(($urandom_range(0, 99) < tok_pct) ? rand_tok() : rand_data(),
              ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++; $display("FAIL random cyc %0d got %b want %b", i, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      en = 1'b1;
      datain = 10'd0;
      rst = 1'b1;
      model_reset();
      test_reset();
      test_lock_basic();
      test_slip_single();
      test_sweep();
      test_loss();
      test_run_break();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
